// File: rtl/inv_key_sched.sv
// AES-128 reverse key schedule: starting from the round-10 key, emits round keys 10 down to 0
// over a valid/ready handshake, stepping backwards one round per accepted key.
module inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] key_out,
    output logic [3:0]   round_out,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W   = 128;
    localparam int unsigned ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(10);

    // Forward AES S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TABLE[{~a, 3'b000} +: 8];
    endfunction

    // Rcon of the round being left
    function automatic logic [7:0] rcon(input logic [ROUND_W-1:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [KEY_W-1:0]     r_key;
    logic [KEY_W-1:0]     w_key_nxt;
    logic [ROUND_W-1:0]   r_round;
    logic [ROUND_W-1:0]   w_round_nxt;
    logic                 r_key_valid;
    logic                 r_busy;
    logic                 r_done;

    logic [31:0]          w_p0;
    logic [31:0]          w_p1;
    logic [31:0]          w_p2;
    logic [31:0]          w_p3;
    logic [31:0]          w_rot;
    logic [31:0]          w_sub;
    logic [KEY_W-1:0]     w_key_prev;

    // Undo one forward expansion step
    always_comb begin
        w_p3       = r_key[31:0]  ^ r_key[63:32];
        w_p2       = r_key[63:32] ^ r_key[95:64];
        w_p1       = r_key[95:64] ^ r_key[127:96];
        w_rot      = {w_p3[23:0], w_p3[31:24]};
        w_sub      = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                      sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
        w_p0       = r_key[127:96] ^ w_sub ^ {rcon(r_round), 24'h000000};
        w_key_prev = {w_p0, w_p1, w_p2, w_p3};
    end

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_round_nxt = r_round;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_key_nxt   = key_in;
                    w_round_nxt = LAST_ROUND;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (key_ready) begin
                    if (r_round == ROUND_W'(0)) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_key_nxt   = w_key_prev;
                        w_round_nxt = ROUND_W'(r_round - ROUND_W'(1));
                    end
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_key       <= '0;
            r_round     <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key       <= w_key_nxt;
            r_round     <= w_round_nxt;
            r_key_valid <= (w_state_nxt == S_EMIT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_FIN);
        end
    end

    assign key_out   = r_key;
    assign round_out = r_round;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched: expected round keys come from a forward AES-128 key expansion
// built on a GF(2^8)-derived S-box, compared against the reverse sequence the DUT emits.
module tb_inv_key_sched;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] key_out;
    logic [3:0]   round_out;
    logic         key_valid;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_keys [11];
    logic [127:0] got_keys [11];

    typedef struct {
        logic [127:0] key_in;
        int           round;
        logic [127:0] exp_key;
    } vec_t;
    vec_t vecs [3];

    inv_key_sched dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .key_ready (key_ready),
        .key_out   (key_out),
        .round_out (round_out),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    // S-box from multiplicative inverse plus affine map
    task automatic init_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_tab[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    // Forward expansion from the round-0 key; fills exp_keys[0..10]
    task automatic build_model(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; runs a full schedule against exp_keys, returns cycles to done
    task automatic run_and_check(input logic [127:0] k10, input bit rnd_ready,
                                 input bit pulse_start, output int n_cyc);
        int   next_round = 10;
        int   cyc = 0;
        int   d0 = done_cnt;
        logic rdy;
        start = 1'b1; key_in = k10; key_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; key_in = rand128();
        check("latency_valid", 128'(key_valid), 128'(1));
        check("latency_round", 128'(round_out), 128'(10));
        while (next_round >= 0) begin
            if (cyc >= 200) begin
                fail_timeout("run_timeout");
                break;
            end
            check("valid", 128'(key_valid), 128'(1));
            check("round", 128'(round_out), 128'(next_round));
            check("key", key_out, exp_keys[next_round]);
            check("done_low", 128'(done), 128'(0));
            rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            key_ready = rdy;
            start = pulse_start && (round_out == 4'd7 || round_out == 4'd0);
            key_in = rand128();
            if (rdy) got_keys[next_round] = key_out;
            @(negedge clk);
            if (rdy) next_round--;
            cyc++;
        end
        n_cyc = cyc + 1;
        check("fin_done", 128'(done), 128'(1));
        check("fin_valid", 128'(key_valid), 128'(0));
        check("fin_busy", 128'(busy), 128'(1));
        start = pulse_start;
        key_in = rand128();
        @(negedge clk);
        start = 1'b0;
        check("idle_done", 128'(done), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_valid", 128'(key_valid), 128'(0));
        check("done_count", 128'(done_cnt), 128'(d0 + 1));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail_timeout("done_timeout");
        @(negedge clk);
    endtask

    initial begin
        int           n;
        int           d0;
        logic [127:0] k;

        rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
        init_sbox();
        vecs[0] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 9,  128'hac7766f319fadc2128d12941575c006e};
        vecs[2] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        repeat (2) @(negedge clk);
        check("rst_key", key_out, 128'(0));
        check("rst_round", 128'(round_out), 128'(0));
        check("rst_valid", 128'(key_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        rst = 1'b0;

        // Known-answer run, key_ready held high
        build_model(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_and_check(vecs[0].key_in, 1'b0, 1'b0, n);
        check("done_latency", 128'(n), 128'(12));
        for (int i = 0; i < 3; i++)
            check($sformatf("fips_round%0d", vecs[i].round), got_keys[vecs[i].round], vecs[i].exp_key);

        // Backpressure on round 9
        d0 = done_cnt;
        start = 1'b1; key_in = vecs[0].key_in; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bp_round10", 128'(round_out), 128'(10));
        @(negedge clk);
        key_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_key", key_out, vecs[1].exp_key);
            check("bp_hold_round", 128'(round_out), 128'(9));
            @(negedge clk);
        end
        key_ready = 1'b1;
        @(negedge clk);
        check("bp_round8", 128'(round_out), 128'(8));
        check("bp_key8", key_out, exp_keys[8]);
        wait_done();
        check("bp_done_count", 128'(done_cnt), 128'(d0 + 1));

        // start pulses mid-run and in FIN are ignored
        build_model(rand128());
        run_and_check(exp_keys[10], 1'b0, 1'b1, n);

        // Back-to-back runs
        build_model(rand128());
        run_and_check(exp_keys[10], 1'b0, 1'b0, n);
        build_model(rand128());
        run_and_check(exp_keys[10], 1'b1, 1'b0, n);

        // Asynchronous reset at round 4
        build_model(rand128());
        d0 = done_cnt;
        start = 1'b1; key_in = exp_keys[10]; key_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (round_out != 4'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (round_out != 4'd4) fail_timeout("round4_timeout");
        #2 rst = 1'b1;
        #1;
        check("arst_key", key_out, 128'(0));
        check("arst_round", 128'(round_out), 128'(0));
        check("arst_valid", 128'(key_valid), 128'(0));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_done", 128'(done), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        build_model(rand128());
        run_and_check(exp_keys[10], 1'b0, 1'b0, n);
        check("arst_done_count", 128'(done_cnt), 128'(d0 + 1));

        // Random keys with random backpressure
        for (int r = 0; r < 100; r++) begin
            k = rand128();
            build_model(k);
            run_and_check(exp_keys[10], 1'b1, ($urandom_range(0, 3) == 0), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
